// File: rtl/switch_pkg.sv
// Shared types and constants for the switch debouncer: per-channel FSM state
// encoding and the default stability window (10 ms at 125 MHz).
package switch_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } sw_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 1250000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: 2-flop synchronizer, 4-state stability FSM,
// registered level and optional edge pulses (SWITCH_DEBOUNCER_EDGE_EN).
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_sw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  sw_state_e        r_state;
  sw_state_e        w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next_count;
  logic             r_level;
  logic             w_next_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer to one stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      STABLE_LOW: begin
        if (r_sync2) begin
          w_next_state = PEND_HIGH;
          w_next_count = '0;
        end
      end
      PEND_HIGH: begin
        if (!r_sync2) begin
          w_next_state = STABLE_LOW;
          w_next_count = '0;
        end else if (r_count == CNT_LAST) begin
          w_next_state = STABLE_HIGH;
          w_next_count = '0;
        end else begin
          w_next_count = r_count + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!r_sync2) begin
          w_next_state = PEND_LOW;
          w_next_count = '0;
        end
      end
      PEND_LOW: begin
        if (r_sync2) begin
          w_next_state = STABLE_HIGH;
          w_next_count = '0;
        end else if (r_count == CNT_LAST) begin
          w_next_state = STABLE_LOW;
          w_next_count = '0;
        end else begin
          w_next_count = r_count + CNT_W'(1);
        end
      end
    endcase
  end

  // Level decoded from the next state so it changes on the same edge as the FSM.
  assign w_next_level = (w_next_state == STABLE_HIGH) || (w_next_state == PEND_LOW);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE_LOW;
      r_count <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_level <= w_next_level;
    end
  end

  assign o_level = r_level;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_next_level & ~r_level;
      r_fall <= ~w_next_level & r_level;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel board switch debouncer; each channel is an independent
// debounce_channel. Edge pulses are built only with SWITCH_DEBOUNCER_EDGE_EN.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int NUM_SW          = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] switch_in,
  output logic [NUM_SW-1:0] switch_out,
  output logic [NUM_SW-1:0] switch_rise,
  output logic [NUM_SW-1:0] switch_fall
);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clock   (clock),
      .reset_n (reset_n),
      .i_sw    (switch_in[g]),
      .o_level (switch_out[g]),
      .o_rise  (switch_rise[g]),
      .o_fall  (switch_fall[g])
    );
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter NUM_SW, default 1, number of independent switch channels (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1250000 (10 ms at 125 MHz), consecutive stable clocks required to accept a new level; legal minimum 2.
REQ-003 Port clock, input, 1, single clock for all logic; rising-edge active.
REQ-004 Port reset_n, input, 1, asynchronous, active-low reset.
REQ-005 Port switch_in, input, NUM_SW, raw asynchronous board switch levels.
REQ-006 Port switch_out, output, NUM_SW, debounced level per channel; drives the processor SWITCH_in (bit 0).
REQ-007 Port switch_rise, output, NUM_SW, one-clock pulse when the debounced level goes 0->1.
REQ-008 Port switch_fall, output, NUM_SW, one-clock pulse when the debounced level goes 1->0.

Function
REQ-009 Each channel SHALL pass switch_in through a 2-flop synchronizer before any other logic; no combinational path from switch_in to any output.
REQ-010 Each channel SHALL run a 4-state FSM: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-011 STABLE_LOW: sync level 1 -> PEND_HIGH with counter cleared to 0; else hold.
REQ-012 PEND_HIGH: sync 0 -> STABLE_LOW, counter cleared; sync 1 and counter == DEBOUNCE_CYCLES-1 -> STABLE_HIGH; else counter +1.
REQ-013 STABLE_HIGH and PEND_LOW SHALL mirror REQ-011/012 with levels inverted.
REQ-014 switch_out SHALL be 1 exactly in STABLE_HIGH and PEND_LOW, registered.
REQ-015 Latency: raw level held constant from edge k changes switch_out at edge k+DEBOUNCE_CYCLES+2.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES synchronized clocks SHALL leave switch_out unchanged.
REQ-017 Counter width SHALL be clog2(DEBOUNCE_CYCLES); counter SHALL never wrap, saturating path impossible by REQ-012.
REQ-018 switch_rise/switch_fall SHALL assert for exactly one clock, on the same edge switch_out changes; never both in one cycle for one channel.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels each debounce and pulse on their own schedule.

Reset
REQ-020 reset_n low SHALL immediately force synchronizer flops, counters, switch_out, switch_rise, switch_fall to 0 and FSM to STABLE_LOW.
REQ-021 Reset asserted mid-PEND SHALL discard the pending count; no pulse on reset entry or exit.
REQ-022 Switch held high through reset release SHALL produce switch_out=1 and one switch_rise pulse DEBOUNCE_CYCLES+2 clocks after release.

Configuration
REQ-023 Macro SWITCH_DEBOUNCER_EDGE_EN defined: switch_rise/switch_fall generated per REQ-018.
REQ-024 Macro undefined: edge-detect logic omitted; switch_rise and switch_fall tied to 0; switch_out behaviour unchanged.

Structure
REQ-025 Shared package switch_pkg SHALL hold the FSM state typedef (2-bit enum, the four states) and default DEBOUNCE_CYCLES constant.
REQ-026 Per-channel logic SHALL live in sub-module debounce_channel, instantiated NUM_SW times by a generate loop in switch_debouncer.

Verification (bench uses DEBOUNCE_CYCLES=4, NUM_SW=2)
REQ-027 Reset, then switch_in=2'b01 held from edge 0 -> switch_out[0]=1 and switch_rise[0]=1 for one cycle at edge 6; channel 1 stays 0.
REQ-028 switch_in[0] pulses high for 3 clocks then low -> switch_out[0] stays 0, no rise pulse, FSM returns STABLE_LOW.
REQ-029 From switch_out[0]=1, drop switch_in[0] to 0 for 6 clocks -> switch_out[0]=0 and switch_fall[0] one-cycle pulse at edge 6 after the drop.
REQ-030 reset_n asserted 2 clocks into PEND_HIGH, released with input still high -> outputs 0 immediately; rise occurs 6 edges after release, not earlier.
REQ-031 Both channels toggle same edge -> both switch_out bits and both rise pulses assert on the identical edge.
REQ-032 Build without SWITCH_DEBOUNCER_EDGE_EN, repeat REQ-027 -> switch_out identical, switch_rise/switch_fall constant 0.
